// File: rtl/data_ram_responder.sv
// data_ram_responder: responder end of the core data-memory port with a posted write buffer
// Ports:
//   clka         clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   data_ram_ena request valid; write_mask==0 means read, otherwise write
//   write_mask   byte write enables, bit i covers bits [8i+7:8i]
//   addr         byte address, word index addr[ADDR_WIDTH+1:2]
//   mem_wdata    write data, applied per mask lane
//   mem_rdata    read data for the previous cycle's read, held until the next read completes
//   rdata_valid  one-cycle pulse when mem_rdata carries a read result
//   mem_stall    write not accepted this cycle, core holds the request
//   addr_err     (ADDR_CHECK_EN only) registered out-of-range flag
// Optional feature macro: ADDR_CHECK_EN (range-checks upper address bits; otherwise they alias)
module data_ram_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int WB_DEPTH   = 2
) (
    input  logic        clka,
    input  logic        rst,
    input  logic        data_ram_ena,
    input  logic [3:0]  write_mask,
    input  logic [31:0] addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        rdata_valid,
    output logic        mem_stall
`ifdef ADDR_CHECK_EN
    ,
    output logic        addr_err
`endif
);
    localparam int CW = $clog2(WB_DEPTH + 1);
    localparam int EW = ADDR_WIDTH + 36;
    localparam logic [CW-1:0] FULL = CW'(WB_DEPTH);

    logic [31:0] mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] idx;
    logic in_range, rd_req, rd, wr, full, drain, push, rd_q;
    logic [CW-1:0] count_q, count_d, wpos;
    // Entry layout {word index, mask, data}; slot 0 is the oldest.
    logic [WB_DEPTH-1:0][EW-1:0] wb_q, wb_d;
    logic [31:0] ram_q, fwd_q, fwd_d, lane;
    logic [3:0] fmask_q, fmask_d;
    logic unused_addr;

    assign idx = addr[ADDR_WIDTH+1:2];
    assign unused_addr = ^{addr[31:ADDR_WIDTH+2], addr[1:0]};
`ifdef ADDR_CHECK_EN
    assign in_range = addr[31:ADDR_WIDTH+2] == '0;
`else
    assign in_range = 1'b1;
`endif
    assign rd_req = data_ram_ena & (write_mask == 4'b0);
    assign rd = rd_req & in_range;
    assign wr = data_ram_ena & (write_mask != 4'b0) & in_range;
    assign full = count_q == FULL;
    assign mem_stall = wr & full & ~rst;
    // Reads own the array port; a stalled write forces a drain so it fits next cycle.
    assign drain = (count_q != '0) & (~data_ram_ena | (wr & full)) & ~rst;
    assign push = wr & ~full;
    assign wpos = count_q - CW'(drain);

    always_comb begin
        wb_d = drain ? (wb_q >> EW) : wb_q;
        for (int i = 0; i < WB_DEPTH; i++)
            if (push && CW'(i) == wpos) wb_d[i] = {idx, write_mask, mem_wdata};
        count_d = count_q + CW'(push) - CW'(drain);
        fwd_d = '0;
        fmask_d = '0;
        // Oldest to newest so the newest pending byte wins per lane.
        for (int i = 0; i < WB_DEPTH; i++)
            if (CW'(i) < count_q && wb_q[i][EW-1:36] == idx)
                for (int b = 0; b < 4; b++)
                    if (wb_q[i][32+b]) begin
                        fwd_d[8*b+:8] = wb_q[i][8*b+:8];
                        fmask_d[b] = 1'b1;
                    end
        // Out-of-range reads return zero by forcing every lane from the zero image.
        if (!in_range) begin
            fwd_d = '0;
            fmask_d = 4'hF;
        end
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            count_q <= '0;
            wb_q <= '0;
            fwd_q <= '0;
            fmask_q <= 4'hF;
            rd_q <= 1'b0;
        end else begin
            count_q <= count_d;
            wb_q <= wb_d;
            rd_q <= rd_req;
            if (rd_req) begin
                fwd_q <= fwd_d;
                fmask_q <= fmask_d;
            end
        end
    end

    always_ff @(posedge clka) begin
        if (drain)
            for (int b = 0; b < 4; b++)
                if (wb_q[0][32+b]) mem[wb_q[0][EW-1:36]][8*b+:8] <= wb_q[0][8*b+:8];
        if (rd) ram_q <= mem[idx];
    end

    // All-ones lane mask after reset makes mem_rdata read as zero.
    assign lane = {{8{fmask_q[3]}}, {8{fmask_q[2]}}, {8{fmask_q[1]}}, {8{fmask_q[0]}}};
    assign mem_rdata = (fwd_q & lane) | (ram_q & ~lane);
    assign rdata_valid = rd_q;

`ifdef ADDR_CHECK_EN
    logic err_q;
    always_ff @(posedge clka) begin
        if (rst) err_q <= 1'b0;
        else err_q <= data_ram_ena & ~in_range;
    end
    assign addr_err = err_q;
`endif
endmodule

// File: doc/data_ram_responder.md
Name: data_ram_responder

Overview:
- Responder end of the CPU core's data-memory port.
- Accepts the core's request: enable, 32-bit byte address (ALU result), 32-bit write data and 4-bit byte write mask. Returns read data one cycle later.
- Writes go through a small posted write buffer, which drains into a single-port word array.
- Reads forward pending buffered bytes, so the core always sees its own latest stores.
- Asserts a stall when the buffer cannot accept a write.

Parameters:
- ADDR_WIDTH, 10, word-address bits; array depth is 2^ADDR_WIDTH 32-bit words.
- WB_DEPTH, 2, write-buffer entries; legal range 1..4.

Ports:
- clka  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- data_ram_ena  in  1  request valid this cycle.
- write_mask  in  4  byte write enables; bit i covers bits [8i+7:8i]. 4'b0000 with ena high means read.
- addr  in  32  byte address; word index is addr[ADDR_WIDTH+1:2]; addr[1:0] ignored.
- mem_wdata  in  32  write data, applied per mask lane.
- mem_rdata  out  32  read data for the previous cycle's read.
- rdata_valid  out  1  high for one cycle when mem_rdata carries a read result.
- mem_stall  out  1  write not accepted this cycle; core must hold the request unchanged.
- addr_err  out  1  only present with ADDR_CHECK_EN; see Optional Feature.

Behaviour:
- Reset:
  - Write buffer emptied; pending writes are discarded.
  - mem_rdata=0, rdata_valid=0, mem_stall=0, addr_err=0.
  - Array contents are not initialised.
- Request types:
  - read = ena & (mask==0).
  - write = ena & (mask!=0).
- Write buffer:
  - In-order FIFO of {word index, data, mask}, with count 0..WB_DEPTH.
  - A write is accepted (pushed) when count<WB_DEPTH, or when count==WB_DEPTH and a drain occurs in the same cycle.
  - mem_stall = write & (count==WB_DEPTH) is combinational. The forced drain in that cycle means the held write is accepted the next cycle, so the stall lasts exactly 1 cycle.
- Drain:
  - Head entry is written to the array with its byte mask. Unmasked bytes are preserved.
  - Drain occurs when count>0 and (ena==0 or (write and count==WB_DEPTH)).
  - Reads always own the array port; no drain happens in a read cycle.
  - Push and drain in the same cycle: count unchanged.
- Read:
  - Array read is synchronous.
  - In the request cycle, every valid buffer entry with a matching word index is merged over an all-zero byte image, oldest to newest, so the newest byte wins per lane. The merged bytes and the accumulated lane mask are registered.
  - Next cycle, mem_rdata = forwarded bytes where the lane mask is set, array bytes elsewhere; rdata_valid=1.
  - mem_rdata holds its value until the next read completes. rdata_valid is low in non-read cycles.
- Write-after-read and read-after-write to the same word in consecutive cycles need no stall; forwarding covers the second case.
- A write never changes the value returned for a read issued in the same or an earlier cycle.
- rst asserted mid-operation: pending buffered writes are lost and an in-flight read returns nothing (rdata_valid=0 next cycle).

Optional Feature:
- Macro: ADDR_CHECK_EN.
- Defined:
  - A request with addr[31:ADDR_WIDTH+2]!=0 is out of range.
  - It raises addr_err for exactly the following cycle (registered).
  - An out-of-range write is dropped: not pushed, never stalls.
  - An out-of-range read returns 32'h0 with rdata_valid=1.
- Not defined:
  - No addr_err port.
  - Upper address bits are ignored and addresses alias modulo the array size.

Test Plan:
- Write 0x100 data 0xDEADBEEF mask 4'hF, idle 2 cycles, read 0x100 -> next cycle mem_rdata=0xDEADBEEF, rdata_valid=1.
- Write 0x20 0x11223344 mask F, then next cycle write 0x20 0xAABBCCDD mask 4'b0101, then immediately read 0x20 (no idle, both still buffered) -> mem_rdata=0x11BB33DD.
- WB_DEPTH=2: writes to 0x0, 0x4, 0x8 on consecutive cycles -> mem_stall=1 only in the third cycle; third write accepted the next cycle; reads later return all three values.
- Back-to-back reads for 5 cycles with 2 buffered writes -> count stays 2 (no drain), forwarded data correct; first idle cycle drains one entry.
- Assert rst while 2 writes are buffered and a read is issued -> next cycle rdata_valid=0, mem_stall=0; later read of those words returns prior array contents.
- ADDR_CHECK_EN: write to 0x0001_0000 (ADDR_WIDTH=10) -> addr_err=1 next cycle, mem_stall=0, array unchanged; read same address -> mem_rdata=0, rdata_valid=1.
